// File: rtl/param_seq_control_unit_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, ALU op codes
// and the T0..T3 step encodings.
package cpu_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_MVNZ = 3'b101;
  localparam logic [2:0] OP_LD   = 3'b110;
  localparam logic [2:0] OP_ST   = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  // Map an arithmetic opcode to its ALU code; the reserved code never appears.
  function automatic logic [1:0] alu_code(input logic [2:0] op);
    case (op)
      OP_SUB:  alu_code = ALU_SUB;
      OP_AND:  alu_code = ALU_AND;
      default: alu_code = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/param_seq_control_unit_reg_sel_decoder.sv
// Register-select decoder: binary select field to an at-most-one-hot enable
// vector; all zeros when the enable input is low.
module reg_sel_decoder #(
  parameter int NUM_REGS  = 8,
  parameter int REG_SEL_W = 3
) (
  input  logic                 en,
  input  logic [REG_SEL_W-1:0] sel,
  output logic [NUM_REGS-1:0]  onehot
);

  localparam logic [NUM_REGS-1:0] ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

  // Shift a single set bit into the selected position.
  always_comb begin
    onehot = '0;
    if (en) onehot = ONE << sel;
  end

endmodule

// File: rtl/param_seq_control_unit.sv
// Multicycle processor control unit with internal step counter and
// instruction register. Sequences T0 (fetch) through T3 and drives one-hot
// register enables, bus drivers, ALU op and the memory handshake.
module param_seq_control_unit
  import cpu_pkg::*;
#(
  parameter int NUM_REGS    = 8,
  parameter int REG_SEL_W   = 3,
  localparam int INSTR_WIDTH = 3 + 2*REG_SEL_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic                   g_nz,
  input  logic                   mem_ready,
  output logic [NUM_REGS-1:0]    reg_out,
  output logic [NUM_REGS-1:0]    reg_in,
  output logic                   din_out,
  output logic                   g_out,
  output logic                   ir_in,
  output logic                   a_in,
  output logic                   g_in,
  output logic                   addr_in,
  output logic                   dout_in,
  output logic                   w_en,
  output logic [1:0]             alu_op,
  output logic                   done,
  output logic                   busy
);

  logic [1:0]             state, state_nxt;
  logic [INSTR_WIDTH-1:0] ir_q;
  logic [2:0]             op;
  logic [REG_SEL_W-1:0]   x, y;
  logic [REG_SEL_W-1:0]   out_sel, in_sel;
  logic                   out_en, in_en;
  logic                   din_c, gout_c, irin_c, ain_c, gin_c;
  logic                   addr_c, dout_c, wen_c, done_c;
  logic [1:0]             alu_c;

  assign op = ir_q[INSTR_WIDTH-1 -: 3];
  assign x  = ir_q[2*REG_SEL_W-1 -: REG_SEL_W];
  assign y  = ir_q[REG_SEL_W-1:0];

  // Step sequencing and per-step control decode; everything defaults off.
  always_comb begin
    state_nxt = state;
    out_en = 1'b0; out_sel = y;
    in_en  = 1'b0; in_sel  = x;
    din_c = 1'b0; gout_c = 1'b0; irin_c = 1'b0; ain_c = 1'b0; gin_c = 1'b0;
    addr_c = 1'b0; dout_c = 1'b0; wen_c = 1'b0; done_c = 1'b0;
    alu_c = ALU_ADD;
    case (state)
      T0: begin
        if (run) begin
          irin_c = 1'b1; din_c = 1'b1; state_nxt = T1;
        end
      end
      T1: begin
        case (op)
          OP_MV:   begin out_en = 1'b1; in_en = 1'b1; done_c = 1'b1; state_nxt = T0; end
          OP_MVI:  begin din_c = 1'b1; in_en = 1'b1; done_c = 1'b1; state_nxt = T0; end
          OP_MVNZ: begin
            out_en = g_nz; in_en = g_nz; done_c = 1'b1; state_nxt = T0;
          end
          OP_LD, OP_ST: begin out_en = 1'b1; addr_c = 1'b1; state_nxt = T2; end
          default: begin out_sel = x; out_en = 1'b1; ain_c = 1'b1; state_nxt = T2; end
        endcase
      end
      T2: begin
        case (op)
          OP_LD: begin
            if (mem_ready) begin
              din_c = 1'b1; in_en = 1'b1; done_c = 1'b1; state_nxt = T0;
            end
          end
          OP_ST: begin
            out_sel = x; out_en = 1'b1; dout_c = 1'b1; wen_c = 1'b1;
            if (mem_ready) begin done_c = 1'b1; state_nxt = T0; end
          end
          default: begin
            out_en = 1'b1; gin_c = 1'b1; alu_c = alu_code(op); state_nxt = T3;
          end
        endcase
      end
      default: begin
        gout_c = 1'b1; in_en = 1'b1; done_c = 1'b1; state_nxt = T0;
      end
    endcase
  end

  // Step register and instruction register; ir_q loads only on a fetch edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= T0;
      ir_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == T0 && run) ir_q <= instr;
    end
  end

  reg_sel_decoder #(.NUM_REGS(NUM_REGS), .REG_SEL_W(REG_SEL_W)) u_out_dec (
    .en(out_en & ~rst), .sel(out_sel), .onehot(reg_out)
  );

  reg_sel_decoder #(.NUM_REGS(NUM_REGS), .REG_SEL_W(REG_SEL_W)) u_in_dec (
    .en(in_en & ~rst), .sel(in_sel), .onehot(reg_in)
  );

  // Reset overrides every output regardless of the current step.
  always_comb begin
    din_out = din_c  & ~rst;
    g_out   = gout_c & ~rst;
    ir_in   = irin_c & ~rst;
    a_in    = ain_c  & ~rst;
    g_in    = gin_c  & ~rst;
    addr_in = addr_c & ~rst;
    dout_in = dout_c & ~rst;
    w_en    = wen_c  & ~rst;
    alu_op  = rst ? 2'b00 : alu_c;
    done    = done_c & ~rst;
    busy    = (state != T0) & ~rst;
  end

endmodule

// File: tb/tb_param_seq_control_unit.sv
// Bench for param_seq_control_unit: directed cases plus randomized
// instructions checked against an instruction-level expectation model.
module tb_param_seq_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       run, g_nz, mem_ready;
  logic [8:0] instr;
  logic [7:0] reg_out, reg_in;
  logic       din_out, g_out, ir_in, a_in, g_in, addr_in, dout_in, w_en, done, busy;
  logic [1:0] alu_op;

  logic       run4, g_nz4, mem_ready4;
  logic [6:0] instr4;
  logic [3:0] reg_out4, reg_in4;
  logic       din_out4, g_out4, ir_in4, a_in4, g_in4, addr_in4, dout_in4, w_en4, done4, busy4;
  logic [1:0] alu_op4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_seq_control_unit #(.NUM_REGS(8), .REG_SEL_W(3)) dut (
    .clk(clk), .rst(rst), .run(run), .instr(instr), .g_nz(g_nz), .mem_ready(mem_ready),
    .reg_out(reg_out), .reg_in(reg_in), .din_out(din_out), .g_out(g_out), .ir_in(ir_in),
    .a_in(a_in), .g_in(g_in), .addr_in(addr_in), .dout_in(dout_in), .w_en(w_en),
    .alu_op(alu_op), .done(done), .busy(busy)
  );

  param_seq_control_unit #(.NUM_REGS(4), .REG_SEL_W(2)) dut4 (
    .clk(clk), .rst(rst), .run(run4), .instr(instr4), .g_nz(g_nz4), .mem_ready(mem_ready4),
    .reg_out(reg_out4), .reg_in(reg_in4), .din_out(din_out4), .g_out(g_out4), .ir_in(ir_in4),
    .a_in(a_in4), .g_in(g_in4), .addr_in(addr_in4), .dout_in(dout_in4), .w_en(w_en4),
    .alu_op(alu_op4), .done(done4), .busy(busy4)
  );

  logic [27:0] obs;
  assign obs = {reg_out, reg_in, din_out, g_out, ir_in, a_in, g_in, addr_in,
                dout_in, w_en, alu_op, done, busy};
  logic [19:0] obs4;
  assign obs4 = {reg_out4, reg_in4, din_out4, g_out4, ir_in4, a_in4, g_in4, addr_in4,
                 dout_in4, w_en4, alu_op4, done4, busy4};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] oh(input int i);
    logic [7:0] one = 8'd1;
    return one << i;
  endfunction

  // Expected output word for one step, fields in the same order as obs.
  function automatic logic [27:0] ev(input logic [7:0] ro, input logic [7:0] ri,
      input bit din, input bit gout, input bit irin, input bit ain, input bit gin,
      input bit addr, input bit dout, input bit wen, input logic [1:0] alu,
      input bit dn, input bit bsy);
    return {ro, ri, din, gout, irin, ain, gin, addr, dout, wen, alu, dn, bsy};
  endfunction

  logic [27:0] expq[$];
  int          mrq[$];

  // Build the expected per-step behaviour of one instruction from its meaning.
  task automatic build(input int op, input int x, input int y, input bit gnz, input int stall);
    expq.delete(); mrq.delete();
    case (op)
      0: begin expq.push_back(ev(oh(y), oh(x), 0,0,0,0,0,0,0,0, 2'd0, 1, 1)); mrq.push_back(-1); end
      1: begin expq.push_back(ev(8'd0, oh(x), 1,0,0,0,0,0,0,0, 2'd0, 1, 1)); mrq.push_back(-1); end
      2, 3, 4: begin
        expq.push_back(ev(oh(x), 8'd0, 0,0,0,1,0,0,0,0, 2'd0, 0, 1)); mrq.push_back(-1);
        expq.push_back(ev(oh(y), 8'd0, 0,0,0,0,1,0,0,0, 2'(op - 2), 0, 1)); mrq.push_back(-1);
        expq.push_back(ev(8'd0, oh(x), 0,1,0,0,0,0,0,0, 2'd0, 1, 1)); mrq.push_back(-1);
      end
      5: begin
        expq.push_back(ev(gnz ? oh(y) : 8'd0, gnz ? oh(x) : 8'd0, 0,0,0,0,0,0,0,0, 2'd0, 1, 1));
        mrq.push_back(-1);
      end
      6: begin
        expq.push_back(ev(oh(y), 8'd0, 0,0,0,0,0,1,0,0, 2'd0, 0, 1)); mrq.push_back(-1);
        for (int i = 0; i < stall; i++) begin
          expq.push_back(ev(8'd0, 8'd0, 0,0,0,0,0,0,0,0, 2'd0, 0, 1)); mrq.push_back(0);
        end
        expq.push_back(ev(8'd0, oh(x), 1,0,0,0,0,0,0,0, 2'd0, 1, 1)); mrq.push_back(1);
      end
      default: begin
        expq.push_back(ev(oh(y), 8'd0, 0,0,0,0,0,1,0,0, 2'd0, 0, 1)); mrq.push_back(-1);
        for (int i = 0; i <= stall; i++) begin
          expq.push_back(ev(oh(x), 8'd0, 0,0,0,0,0,0,1,1, 2'd0, i == stall, 1));
          mrq.push_back(i == stall ? 1 : 0);
        end
      end
    endcase
  endtask

  // Fetch from T0, then walk every expected step. Starts and ends just after a posedge.
  task automatic do_instr(input string tag, input int op, input int x, input int y,
                          input bit gnz, input int stall);
    build(op, x, y, gnz, stall);
    run = 1'b1; instr = {3'(op), 3'(x), 3'(y)};
    g_nz = (op == 5) ? gnz : 1'($urandom); mem_ready = 1'($urandom);
    #1 chk({tag, "_t0"}, 32'(obs), 32'(ev(8'd0, 8'd0, 1,0,1,0,0,0,0,0, 2'd0, 0, 0)));
    @(posedge clk); #1;
    for (int k = 0; k < expq.size(); k++) begin
      run = 1'($urandom); instr = 9'($urandom);
      g_nz = (op == 5) ? gnz : 1'($urandom);
      mem_ready = (mrq[k] < 0) ? 1'($urandom) : 1'(mrq[k]);
      #1 chk($sformatf("%s_s%0d", tag, k), 32'(obs), 32'(expq[k]));
      @(posedge clk); #1;
    end
    run = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; instr = '0; g_nz = 1'b0; mem_ready = 1'b0;
    run4 = 1'b0; instr4 = '0; g_nz4 = 1'b0; mem_ready4 = 1'b0;
    #3 chk("rst_outs", 32'(obs), 32'd0);
    run = 1'b1;
    #1 chk("rst_run", 32'(obs), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; run = 1'b0;
    #1 chk("idle_t0", 32'(obs), 32'd0);
    @(posedge clk); #1;
    chk("idle_hold", 32'(obs), 32'd0);

    do_instr("mvi_r3", 1, 3, 0, 0, 0);
    #1 chk("mvi_busy_low", 32'(busy), 32'd0);
    do_instr("add_r1r2", 2, 1, 2, 0, 0);
    do_instr("sub_r1r2", 3, 1, 2, 0, 0);
    do_instr("and_r1r2", 4, 1, 2, 0, 0);
    do_instr("add_r2r2", 2, 2, 2, 0, 0);
    do_instr("mvnz_g0", 5, 4, 5, 0, 0);
    do_instr("mvnz_g1", 5, 4, 5, 1, 0);
    do_instr("st_r6r7", 7, 6, 7, 0, 3);
    do_instr("ld_nostall", 6, 0, 1, 0, 0);

    // ld r0,r1 with reset pulsed during the memory stall
    run = 1'b1; instr = {3'd6, 3'd0, 3'd1}; mem_ready = 1'b0;
    @(posedge clk); #1;
    run = 1'b0;
    @(posedge clk); #1;
    #1 chk("ld_stall", 32'(obs), 32'(ev(8'd0, 8'd0, 0,0,0,0,0,0,0,0, 2'd0, 0, 1)));
    #2 rst = 1'b1;
    #1 chk("rst_mid_stall", 32'(obs), 32'd0);
    @(posedge clk); #1;
    mem_ready = 1'b1;
    #1 chk("rst_mid_hold", 32'(obs), 32'd0);
    rst = 1'b0;
    #1 chk("after_rst_t0", 32'(obs), 32'd0);
    @(posedge clk); #1;
    do_instr("post_rst_mv", 0, 5, 6, 0, 0);

    // Four-register variant: mv r3,r0
    run4 = 1'b1; instr4 = 7'b000_11_00;
    #1 chk("r4_fetch", 32'(obs4), 32'({4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 5'd0, 2'd0, 1'b0, 1'b0}));
    @(posedge clk); #1;
    run4 = 1'b0;
    #1 chk("r4_mv", 32'(obs4), 32'({4'b0001, 4'b1000, 8'd0, 2'd0, 1'b1, 1'b1}));
    @(posedge clk); #1;
    chk("r4_idle", 32'(obs4), 32'd0);

    for (int n = 0; n < 60; n++) begin
      do_instr($sformatf("rnd%0d", n), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
